mont_mod_exponent: RTL and testbench
====================================

// Module: mont_mod_exponent
// PURPOSE
//  Computes c = base^exponent mod modulo using Montgomery multiplication (R = 2^WIDTH).
//  It is the RSA encrypt/decrypt engine between the UART/SPI message path and the key-setup logic.
//  It takes one request at a time over a valid/busy input handshake and a valid/ready output handshake.
// PARAMETERS
//  WIDTH  64  operand width in bits; key, modulus and message size
// PORTS
//  clk_in         in   1        system clock; all logic on rising edge
//  rst_in         in   1        synchronous reset, active-low (0 = reset)
//  base           in   WIDTH    message; requires base < modulo
//  exponent       in   WIDTH    exponent (e or d), zero-extended by the caller
//  modulo         in   WIDTH    N; must be odd and > 1
//  inv_modulo     in   WIDTH    N^-1 mod 2^WIDTH, where N*inv_modulo = 1 mod R
//  R              in   WIDTH+1  must equal 2^WIDTH; not used in the datapath (shifts and truncation are used)
//  start_product  in   WIDTH    R mod N, i.e. Montgomery form of 1
//  valid_in       in   1        request strobe
//  c_out          out  WIDTH    result, 0 <= c_out < N
//  valid_out      out  1        result available; held until accepted
//  busy_out       out  1        request in progress or result pending
//  ready_in       in   1        consumer accepts the result
// BEHAVIOUR
//  Reset: c_out=0, valid_out=0, busy_out=0, state=IDLE. Reset in any state aborts the operation next edge.
//  Accept: in IDLE with valid_in=1, latch all data inputs. busy_out=1 from the next cycle.
//    valid_in is ignored while busy_out=1.
//  States: IDLE -> TOMONT -> EXP -> FROMMONT -> DONE -> IDLE.
//  TOMONT: x = base; repeat WIDTH times x = (2x >= N) ? 2x-N : 2x, giving b_m = base*R mod N. One cycle per step.
//  EXP: P = start_product. Scan exponent MSB to LSB over all WIDTH bits.
//    For each bit: P = MM(P,P); then if the bit is 1, P = MM(P,b_m).
//  MM(a,b) runs in 3 cycles:
//    T = a*b (2*WIDTH bits).
//    m = (T mod R)*inv_modulo mod R.
//    t = (T - m*N) >> WIDTH, computed signed with WIDTH+2 bits. If t < 0, t += N.
//  FROMMONT: c = MM(P,1).
//  DONE: valid_out=1 and c_out is stable. A transfer occurs when ready_in=1.
//    On the cycle after the transfer: valid_out=0, busy_out=0, state=IDLE.
//    If valid_in=1 in the same cycle as the transfer, it is ignored.
//  Latency (no macro): 1 + WIDTH + 3*(WIDTH + popcount(exponent)) + 3 cycles from accept to valid_out.
//  Boundaries:
//    exponent=0 -> c=1.
//    base=0 with exponent>0 -> c=0.
//    base >= N or even N -> result undefined (caller contract).
//  No internal overflow: every intermediate value is held in at least WIDTH+2 bits before the final correction.
// CONFIGURATION
//  MOD_EXP_LZ_SKIP_EN defined:
//    EXP first skips leading zero exponent bits at one bit per cycle, with no MM performed.
//    Latency drops accordingly. c_out is bit-identical.
//  MOD_EXP_LZ_SKIP_EN undefined: all WIDTH bits are processed and latency is fixed as stated above.
// STRUCTURE
//  Package mod_exp_pkg holds:
//    state_t enum (IDLE, TOMONT, EXP, FROMMONT, DONE);
//    the MM phase encoding;
//    localparam MM_CYCLES=3.
//  Sub-module mont_mul:
//    3-stage Montgomery product with start/done;
//    ports a, b, n, n_inv and result;
//    instantiated once and reused for square, multiply and exit.
//  Top file holds the FSM, bit counter, exponent shift register and TOMONT doubler.
// TESTING
//  Bench constants: WIDTH=64, N=31439 (211*149), inv_modulo=64'h5733638FBA4C4C2F,
//    start_product=10830, ready_in=1 unless noted.
//  Small cases:
//    base=3, exponent=5 -> c_out=243.
//    base=200, exponent=2 -> c_out=8561.
//    base=2, exponent=10 -> c_out=1024.
//  Edge cases:
//    exponent=0, base=777 -> c_out=1.
//    base=0, exponent=65537 -> c_out=0.
//  Round trip:
//    base=12345, exponent=65537 -> c.
//    Then base=c, exponent=d with d = 65537^-1 mod 31080 -> c_out=12345.
//  Backpressure: hold ready_in=0 for 20 cycles after valid_out rises.
//    valid_out, busy_out and c_out stay stable; a valid_in pulse meanwhile is ignored.
//    Set ready_in=1 -> idle on the next cycle.
//  Reset mid-EXP: drive rst_in=0 for 1 cycle -> valid_out=0, busy_out=0.
//    A new request (base=3, exponent=5) -> c_out=243.
//  Latency: check accept-to-valid_out cycle count against the formula, with and without MOD_EXP_LZ_SKIP_EN.

Source files
------------

// File: rtl/mod_exp_pkg.sv
// Shared types for the Montgomery modular exponentiation engine.
package mod_exp_pkg;

  localparam int unsigned MM_CYCLES = 3;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    TOMONT   = 3'd1,
    EXP      = 3'd2,
    FROMMONT = 3'd3,
    DONE     = 3'd4
  } state_t;

  // Which Montgomery product is in flight during EXP
  typedef enum logic [1:0] {
    PH_START = 2'd0,
    PH_SQR   = 2'd1,
    PH_MUL   = 2'd2
  } mm_phase_t;

endpackage

// File: rtl/mont_mul.sv
// mont_mul: 3-stage Montgomery product result = a*b*R^-1 mod n, R = 2^WIDTH.
// A start pulse yields a one-cycle done pulse three edges later.
module mont_mul #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  input  logic [WIDTH-1:0] n_inv,
  output logic [WIDTH-1:0] result,
  output logic             done
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned SW = 2 * WIDTH + 2;
  localparam int unsigned RW = WIDTH + 2;

  logic [PW-1:0]    t_q, t_d, t2_q, t2_d;
  logic [WIDTH-1:0] m_q, m_d, res_q, res_d;
  logic             v1_q, v1_d, v2_q, v2_d, done_q, done_d;
  logic [RW-1:0]    red_c;

  // Stage 1: full product; stage 2: reduction factor m; stage 3: shift and correct
  always_comb begin
    t_d   = PW'(a) * PW'(b);
    v1_d  = start;
    m_d   = WIDTH'(t_q[WIDTH-1:0] * n_inv);
    t2_d  = t_q;
    v2_d  = v1_q;
    // Two's-complement difference; low WIDTH bits are zero, top RW bits are signed t
    red_c  = RW'((SW'(t2_q) - SW'(m_q) * SW'(n)) >> WIDTH);
    res_d  = res_q;
    if (v2_q) begin
      res_d = red_c[RW-1] ? WIDTH'(red_c + RW'(n)) : WIDTH'(red_c);
    end
    done_d = v2_q;
  end

  // Pipeline registers
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      t_q    <= '0;
      t2_q   <= '0;
      m_q    <= '0;
      res_q  <= '0;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      t_q    <= t_d;
      t2_q   <= t2_d;
      m_q    <= m_d;
      res_q  <= res_d;
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      done_q <= done_d;
    end
  end

  assign result = res_q;
  assign done   = done_q;

endmodule

// File: rtl/mont_mod_exponent.sv
// mont_mod_exponent: c = base^exponent mod modulo, left-to-right square-and-multiply
// in the Montgomery domain with a single shared mont_mul.
// Optional MOD_EXP_LZ_SKIP_EN: skip leading zero exponent bits before the first product.
module mont_mod_exponent
  import mod_exp_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0] modulo,
  input  logic [WIDTH-1:0] inv_modulo,
  input  logic [WIDTH:0]   R,
  input  logic [WIDTH-1:0] start_product,
  input  logic             valid_in,
  output logic [WIDTH-1:0] c_out,
  output logic             valid_out,
  output logic             busy_out,
  input  logic             ready_in
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_t           state_q, state_d;
  mm_phase_t        phase_q, phase_d;
  logic [WIDTH-1:0] x_q, x_d, exp_q, exp_d, n_q, n_d, ninv_q, ninv_d, sp_q, sp_d, c_q, c_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc_c;
  logic             valid_q, valid_d, busy_q, busy_d;
  logic             mm_start_c, mm_done;
  logic [WIDTH-1:0] mm_a_c, mm_b_c, mm_res, exp_shl_c;
  logic [WIDTH:0]   x2_c;
  logic             last_c, bit_c, bit_done_c;
  logic             r_unused_c;

  // R is fixed at 2^WIDTH; the datapath uses truncation instead
  assign r_unused_c = ^R;

  assign last_c     = (cnt_q == CNT_W'(WIDTH - 1));
  assign bit_c      = exp_q[WIDTH-1];
  assign cnt_inc_c  = CNT_W'(cnt_q + CNT_W'(1));
  assign exp_shl_c  = {exp_q[WIDTH-2:0], 1'b0};
  assign x2_c       = {x_q, 1'b0};
  assign bit_done_c = (state_q == EXP) && mm_done &&
                      ((phase_q == PH_MUL) || ((phase_q == PH_SQR) && !bit_c));

  mont_mul #(.WIDTH(WIDTH)) u_mont_mul (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .start  (mm_start_c),
    .a      (mm_a_c),
    .b      (mm_b_c),
    .n      (n_q),
    .n_inv  (ninv_q),
    .result (mm_res),
    .done   (mm_done)
  );

  // State register
  always_ff @(posedge clk_in) begin
    if (!rst_in) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (valid_in)              state_d = TOMONT;
      TOMONT:   if (last_c)                state_d = EXP;
      EXP:      if (bit_done_c && last_c)  state_d = FROMMONT;
      FROMMONT: if (mm_done)               state_d = DONE;
      DONE:     if (ready_in)              state_d = IDLE;
      default:                             state_d = IDLE;
    endcase
  end

  // Datapath, multiplier control and output next values
  always_comb begin
    x_d        = x_q;
    exp_d      = exp_q;
    n_d        = n_q;
    ninv_d     = ninv_q;
    sp_d       = sp_q;
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    c_d        = c_q;
    valid_d    = valid_q;
    busy_d     = busy_q;
    mm_start_c = 1'b0;
    // Running product comes straight from the multiplier once the first product is done
    mm_a_c     = mm_done ? mm_res : sp_q;
    mm_b_c     = mm_done ? mm_res : sp_q;
    unique case (state_q)
      IDLE: begin
        if (valid_in) begin
          x_d    = base;
          exp_d  = exponent;
          n_d    = modulo;
          ninv_d = inv_modulo;
          sp_d   = start_product;
          cnt_d  = '0;
          busy_d = 1'b1;
        end
      end
      TOMONT: begin
        x_d     = WIDTH'((x2_c >= {1'b0, n_q}) ? (x2_c - {1'b0, n_q}) : x2_c);
        cnt_d   = last_c ? '0 : cnt_inc_c;
        phase_d = PH_START;
      end
      EXP: begin
        if (bit_done_c) begin
          exp_d      = exp_shl_c;
          cnt_d      = cnt_inc_c;
          mm_start_c = 1'b1;
          phase_d    = PH_SQR;
          if (last_c) mm_b_c = WIDTH'(1);
        end else if ((phase_q == PH_SQR) && mm_done) begin
          mm_start_c = 1'b1;
          mm_b_c     = x_q;
          phase_d    = PH_MUL;
        end else if (phase_q == PH_START) begin
`ifdef MOD_EXP_LZ_SKIP_EN
          if (!bit_c && !last_c) begin
            exp_d = exp_shl_c;
            cnt_d = cnt_inc_c;
          end else begin
            mm_start_c = 1'b1;
            phase_d    = PH_SQR;
          end
`else
          mm_start_c = 1'b1;
          phase_d    = PH_SQR;
`endif
        end
      end
      FROMMONT: begin
        if (mm_done) begin
          c_d     = mm_res;
          valid_d = 1'b1;
        end
      end
      DONE: begin
        if (ready_in) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      phase_q <= PH_START;
      x_q     <= '0;
      exp_q   <= '0;
      n_q     <= '0;
      ninv_q  <= '0;
      sp_q    <= '0;
      c_q     <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      x_q     <= x_d;
      exp_q   <= exp_d;
      n_q     <= n_d;
      ninv_q  <= ninv_d;
      sp_q    <= sp_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign c_out     = c_q;
  assign valid_out = valid_q;
  assign busy_out  = busy_q;

endmodule

// File: tb/tb_mont_mod_exponent.sv
// Self-checking bench for mont_mod_exponent against a plain modular-power model.
module tb_mont_mod_exponent;
  import mod_exp_pkg::*;

  localparam int unsigned W = 64;
  localparam logic [W-1:0] N_C    = 64'd31439;
  localparam logic [W-1:0] NINV_C = 64'h5733638FBA4C4C2F;
  localparam logic [W-1:0] SP_C   = 64'd10830;

  logic         clk_in = 1'b0;
  logic         rst_in;
  logic [W-1:0] base, exponent, modulo, inv_modulo, start_product;
  logic [W:0]   r_val;
  logic         valid_in, ready_in;
  logic [W-1:0] c_out;
  logic         valid_out, busy_out;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] got, rt_c, rt_d, hold_c;
  bit           seen;

  always #5 clk_in = ~clk_in;

  mont_mod_exponent #(.WIDTH(W)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .base          (base),
    .exponent      (exponent),
    .modulo        (modulo),
    .inv_modulo    (inv_modulo),
    .R             (r_val),
    .start_product (start_product),
    .valid_in      (valid_in),
    .c_out         (c_out),
    .valid_out     (valid_out),
    .busy_out      (busy_out),
    .ready_in      (ready_in)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Right-to-left binary exponentiation with ordinary integer arithmetic
  function automatic logic [W-1:0] ref_pow(input logic [W-1:0] b, input logic [W-1:0] e);
    longint unsigned r = 1;
    longint unsigned x = b % N_C;
    for (int i = 0; i < 64; i++) begin
      if (e[i]) r = (r * x) % N_C;
      x = (x * x) % N_C;
    end
    return W'(r);
  endfunction

  function automatic int exp_lat(input logic [W-1:0] e);
    int pc = 0;
`ifdef MOD_EXP_LZ_SKIP_EN
    int lz = 0;
    bit one_seen = 0;
    for (int i = 63; i >= 0; i--) begin
      if (e[i]) one_seen = 1;
      else if (!one_seen) lz++;
    end
    if (lz > 63) lz = 63;
`endif
    for (int i = 0; i < 64; i++) if (e[i]) pc++;
`ifdef MOD_EXP_LZ_SKIP_EN
    return 1 + 64 + lz + MM_CYCLES * (64 - lz + pc) + MM_CYCLES;
`else
    return 1 + 64 + MM_CYCLES * (64 + pc) + MM_CYCLES;
`endif
  endfunction

  // One request with ready_in held high: checks busy, result, latency and return to idle
  task automatic run_req(input string tag, input logic [W-1:0] b, input logic [W-1:0] e,
                         output logic [W-1:0] res);
    int  cyc = 0;
    bit  vo  = 0;
    @(negedge clk_in);
    base = b; exponent = e; valid_in = 1'b1;
    @(posedge clk_in); #1;
    valid_in = 1'b0;
    base     = W'($urandom);
    exponent = {$urandom, $urandom};
    check({tag, "_busy"}, W'(busy_out), W'(1));
    while (!vo && cyc < 2000) begin
      @(posedge clk_in); #1;
      cyc++;
      vo = valid_out;
    end
    if (!vo) begin
      check({tag, "_timeout"}, W'(0), W'(1));
      res = '0;
      return;
    end
    res = c_out;
    check({tag, "_c"}, c_out, ref_pow(b, e));
    check({tag, "_lat"}, W'(cyc), W'(exp_lat(e)));
    @(posedge clk_in); #1;
    check({tag, "_idle"}, W'({valid_out, busy_out}), W'(0));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
    base = '0; exponent = '0;
    modulo = N_C; inv_modulo = NINV_C; start_product = SP_C;
    r_val = {1'b1, {W{1'b0}}};
    repeat (3) @(posedge clk_in);
    #1;
    check("rst_c", c_out, W'(0));
    check("rst_valid", W'(valid_out), W'(0));
    check("rst_busy", W'(busy_out), W'(0));
    @(negedge clk_in); rst_in = 1'b1;

    run_req("small_3_5", 64'd3, 64'd5, got);      check("small_3_5_k", got, 64'd243);
    run_req("small_200_2", 64'd200, 64'd2, got);  check("small_200_2_k", got, 64'd8561);
    run_req("small_2_10", 64'd2, 64'd10, got);    check("small_2_10_k", got, 64'd1024);
    run_req("exp0", 64'd777, 64'd0, got);         check("exp0_k", got, 64'd1);
    run_req("base0", 64'd0, 64'd65537, got);      check("base0_k", got, 64'd0);
    run_req("maxexp", N_C - 64'd1, {W{1'b1}}, got);

    // Round trip through e = 65537 and its inverse modulo phi(N) = 210*148
    rt_d = '0;
    for (longint unsigned k = 1; k < 31080; k++) begin
      if (((64'd65537 * k) % 64'd31080) == 64'd1) begin
        rt_d = W'(k);
        break;
      end
    end
    run_req("rt_enc", 64'd12345, 64'd65537, rt_c);
    run_req("rt_dec", rt_c, rt_d, got);
    check("rt_plain", got, 64'd12345);

    // Randomized operands with varied exponent length
    for (int i = 0; i < 12; i++) begin
      logic [W-1:0] rb, re;
      rb = W'($urandom_range(0, 31438));
      re = {$urandom, $urandom} >> $urandom_range(0, 63);
      run_req($sformatf("rnd%0d", i), rb, re, got);
    end

    // Backpressure: result held while ready_in is low, valid_in ignored meanwhile
    ready_in = 1'b0;
    @(negedge clk_in); base = 64'd5; exponent = 64'd7; valid_in = 1'b1;
    @(posedge clk_in); #1; valid_in = 1'b0;
    seen = 0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(posedge clk_in); #1;
      seen = valid_out;
    end
    check("bp_valid_rise", W'(seen), W'(1));
    hold_c = c_out;
    check("bp_c", hold_c, ref_pow(64'd5, 64'd7));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_in);
      valid_in = (i == 5);
      base = 64'd9; exponent = 64'd3;
      @(posedge clk_in); #1;
      check($sformatf("bp_hold_c%0d", i), c_out, hold_c);
      check($sformatf("bp_hold_vb%0d", i), W'({valid_out, busy_out}), W'(3));
    end
    @(negedge clk_in); ready_in = 1'b1; valid_in = 1'b1;
    @(posedge clk_in); #1;
    check("bp_release", W'({valid_out, busy_out}), W'(0));
    @(negedge clk_in); valid_in = 1'b0;
    @(posedge clk_in); #1;
    check("bp_no_accept", W'({valid_out, busy_out}), W'(0));

    // Reset in the middle of EXP aborts the request
    @(negedge clk_in); base = 64'd12345; exponent = 64'd65537; valid_in = 1'b1;
    @(posedge clk_in); #1; valid_in = 1'b0;
    repeat (100) @(posedge clk_in);
    @(negedge clk_in); rst_in = 1'b0;
    @(posedge clk_in); #1;
    check("midrst_valid", W'(valid_out), W'(0));
    check("midrst_busy", W'(busy_out), W'(0));
    @(negedge clk_in); rst_in = 1'b1;
    run_req("after_rst", 64'd3, 64'd5, got);
    check("after_rst_k", got, 64'd243);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
